// File: rtl/data_packer_pkg.sv
// Shared types and parameter helpers for the byte-to-word packer.
// Optional per-lane keep mask is enabled with DATA_PACKER_KEEP_EN.
package data_packer_pkg;

   typedef enum logic {
      EMPTY  = 1'b0,
      LOADED = 1'b1
   } out_state_t;

   function automatic int lanes(input int inW, input int outW);
      return outW / inW;
   endfunction

   function automatic bit cfg_ok(input int inW, input int outW);
      return (inW > 0) && ((outW % inW) == 0) && ((outW / inW) >= 2);
   endfunction

endpackage

// File: rtl/packer_out_stage.sv
// Output word register with valid/ready handshake; one-cycle load latency, holds word while stalled.
// Keep mask register present only with DATA_PACKER_KEEP_EN.
module packer_out_stage
   import data_packer_pkg::*;
#(
   parameter int OutWidth = 32
`ifdef DATA_PACKER_KEEP_EN
   ,
   parameter int Ratio    = 4
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic [OutWidth-1:0] load_data_i,
   input  logic                load_last_i,
`ifdef DATA_PACKER_KEEP_EN
   input  logic [Ratio-1:0]    load_keep_i,
   output logic [Ratio-1:0]    out_keep_o,
`endif
   input  logic                out_ready_i,
   output logic                free_o,
   output logic [OutWidth-1:0] out_data_o,
   output logic                out_valid_o,
   output logic                out_last_o
);

   out_state_t          state_q, state_d;
   logic [OutWidth-1:0] data_q, data_d;
   logic                last_q, last_d;
`ifdef DATA_PACKER_KEEP_EN
   logic [Ratio-1:0]    keep_q, keep_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         data_q  <= '0;
         last_q  <= 1'b0;
`ifdef DATA_PACKER_KEEP_EN
         keep_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         last_q  <= last_d;
`ifdef DATA_PACKER_KEEP_EN
         keep_q  <= keep_d;
`endif
      end
   end

   // A load can only arrive when the register is free, so it always wins over the drain.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      last_d  = last_q;
`ifdef DATA_PACKER_KEEP_EN
      keep_d  = keep_q;
`endif
      case (state_q)
         EMPTY: begin
            if (load_i) state_d = LOADED;
         end
         LOADED: begin
            if (load_i)           state_d = LOADED;
            else if (out_ready_i) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
      if (load_i) begin
         data_d = load_data_i;
         last_d = load_last_i;
`ifdef DATA_PACKER_KEEP_EN
         keep_d = load_keep_i;
`endif
      end
   end

   assign out_valid_o = (state_q == LOADED);
   assign free_o      = (state_q == EMPTY) || out_ready_i;
   assign out_data_o  = data_q;
   assign out_last_o  = last_q;
`ifdef DATA_PACKER_KEEP_EN
   assign out_keep_o  = keep_q;
`endif

endmodule

// File: rtl/data_packer.sv
// Packs InWidth-bit beats little-endian into OutWidth-bit words; word valid the cycle after the
// completing beat, input stalls while an unaccepted word is held. outKeep exists with DATA_PACKER_KEEP_EN.
module data_packer
   import data_packer_pkg::*;
#(
   parameter int InWidth  = 8,
   parameter int OutWidth = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [InWidth-1:0]  inData,
   input  logic                inValid,
   output logic                inReady,
   input  logic                inLast,
   output logic [OutWidth-1:0] outData,
   output logic                outValid,
   input  logic                outReady,
`ifdef DATA_PACKER_KEEP_EN
   output logic [lanes(InWidth, OutWidth)-1:0] outKeep,
`endif
   output logic                outLast
);

   localparam int Ratio = lanes(InWidth, OutWidth);
   localparam int CntW  = $clog2(Ratio);
   localparam logic [CntW-1:0] LastLane = CntW'(Ratio - 1);

   if (!cfg_ok(InWidth, OutWidth)) begin : g_cfg_err
      $error("data_packer: OutWidth must be a multiple of InWidth with at least 2 lanes");
   end

   logic [OutWidth-1:0] acc_q, acc_d;
   logic [CntW-1:0]     lane_q, lane_d;
   logic                out_free;
   logic                accept;
   logic                complete;
   logic [OutWidth-1:0] merged_word;
`ifdef DATA_PACKER_KEEP_EN
   logic [Ratio-1:0]    merged_keep;
`endif

   assign inReady  = en && out_free;
   assign accept   = inValid && inReady;
   assign complete = accept && ((lane_q == LastLane) || inLast);

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         lane_q <= '0;
      end else begin
         acc_q  <= acc_d;
         lane_q <= lane_d;
      end
   end

   always_comb begin
      acc_d  = acc_q;
      lane_d = lane_q;
      if (complete) begin
         acc_d  = '0;
         lane_d = '0;
      end else if (accept) begin
         acc_d[lane_q*InWidth +: InWidth] = inData;
         lane_d = lane_q + 1'b1;
      end
   end

   // Lanes above the current one are forced to zero so a short packet is padded.
   always_comb begin
      merged_word = '0;
      for (int k = 0; k < Ratio; k++) begin
         if (CntW'(k) < lane_q)
            merged_word[k*InWidth +: InWidth] = acc_q[k*InWidth +: InWidth];
         else if (CntW'(k) == lane_q)
            merged_word[k*InWidth +: InWidth] = inData;
      end
   end

`ifdef DATA_PACKER_KEEP_EN
   always_comb begin
      merged_keep = '0;
      for (int k = 0; k < Ratio; k++) begin
         merged_keep[k] = (CntW'(k) <= lane_q);
      end
   end
`endif

   packer_out_stage #(
      .OutWidth    (OutWidth)
`ifdef DATA_PACKER_KEEP_EN
      ,
      .Ratio       (Ratio)
`endif
   ) u_out_stage (
      .clk         (clk),
      .reset       (reset),
      .load_i      (complete),
      .load_data_i (merged_word),
      .load_last_i (inLast),
`ifdef DATA_PACKER_KEEP_EN
      .load_keep_i (merged_keep),
      .out_keep_o  (outKeep),
`endif
      .out_ready_i (outReady),
      .free_o      (out_free),
      .out_data_o  (outData),
      .out_valid_o (outValid),
      .out_last_o  (outLast)
   );

endmodule
